predictor_mw: RTL and testbench

//  Multi-lane successor to the fetch-stage predictor: predicts FETCH_WIDTH sequential instructions per cycle.

---
 rtl/predictor_mw.sv | 218 +++++++++++++++++++++
 tb/tb_predictor_mw.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/predictor_mw.sv
// Multi-lane fetch predictor: gshare PHT, tagged direct-mapped BTB, circular RAS and
// speculative GHR, with checkpoint restore of GHR/RAS pointers on flush.
module predictor_mw #(
    parameter int FETCH_WIDTH      = 2,
    parameter int GHR_BITS         = 4,
    parameter int PHT_SIZE         = 2048,
    parameter int BTB_SIZE         = 64,
    parameter int RAS_DEPTH        = 8,
    parameter int PHT_SHARE_ENABLE = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [31:0]                            pc_in,
    input  logic                                   fetch_valid,
    output logic [FETCH_WIDTH-1:0]                 taken_branch,
    output logic [31:0]                            next_pc,
    output logic [GHR_BITS+2*$clog2(RAS_DEPTH):0]  ckpt_out,
    input  logic                                   must_flush,
    input  logic [GHR_BITS+2*$clog2(RAS_DEPTH):0]  flush_ckpt,
    input  logic                                   new_entry,
    input  logic [31:0]                            pc_orig,
    input  logic [31:0]                            target_pc,
    input  logic                                   is_taken,
    input  logic [1:0]                             br_type,
    input  logic [GHR_BITS-1:0]                    upd_ghr,
    input  logic                                   invalidate,
    input  logic [31:0]                            old_pc
);

    localparam int PHT_IDX = $clog2(PHT_SIZE);
    localparam int BTB_IDX = $clog2(BTB_SIZE);
    localparam int RAS_IDX = $clog2(RAS_DEPTH);
    localparam int TAG_W   = 30 - BTB_IDX;

    localparam logic [1:0] BR_COND = 2'b00;
    localparam logic [1:0] BR_CALL = 2'b10;
    localparam logic [1:0] BR_RET  = 2'b11;
    localparam logic [RAS_IDX:0] RAS_FULL = RAS_DEPTH[RAS_IDX:0];

    function automatic logic [PHT_IDX-1:0] pht_index(input logic [PHT_IDX-1:0] pc_bits,
                                                     input logic [GHR_BITS-1:0] g);
        return pc_bits ^ ((PHT_SHARE_ENABLE != 0) ? PHT_IDX'(g) : {PHT_IDX{1'b0}});
    endfunction

    function automatic logic [1:0] pht_sat(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end else begin
            return (c == 2'b00) ? c : c - 2'b01;
        end
    endfunction

    function automatic logic [GHR_BITS-1:0] ghr_shift(input logic [GHR_BITS-1:0] g, input logic b);
        return GHR_BITS'({g, b});
    endfunction

    logic [1:0]          pht        [PHT_SIZE];
    logic [BTB_SIZE-1:0] btb_valid;
    logic [TAG_W-1:0]    btb_tag    [BTB_SIZE];
    logic [31:0]         btb_target [BTB_SIZE];
    logic [1:0]          btb_type   [BTB_SIZE];
    logic [31:0]         ras        [RAS_DEPTH];
    logic [GHR_BITS-1:0] ghr;
    logic [RAS_IDX-1:0]  ras_tos;
    logic [RAS_IDX:0]    ras_cnt;

    logic [31:0]            lane_pc  [FETCH_WIDTH];
    logic [31:0]            lane_tgt [FETCH_WIDTH];
    logic [1:0]             lane_type[FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] lane_taken;
    logic [FETCH_WIDTH-1:0] lane_cond;
    logic [FETCH_WIDTH-1:0] taken_onehot;
    logic [FETCH_WIDTH-1:0] upto_mask;
    logic                   sel_found;
    logic                   sel_is_cond;
    logic                   cond_upto;
    logic [1:0]             sel_type;
    logic [31:0]            sel_tgt;
    logic [31:0]            sel_pc;
    logic [31:0]            next_pc_c;

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
        logic [BTB_IDX-1:0] bidx;
        logic [PHT_IDX-1:0] pidx;
        logic               hit;
        assign lane_pc[i]    = pc_in + 32'(4 * i);
        assign bidx          = lane_pc[i][BTB_IDX+1:2];
        assign pidx          = pht_index(lane_pc[i][PHT_IDX+1:2], ghr);
        assign hit           = btb_valid[bidx] && (btb_tag[bidx] == lane_pc[i][31:BTB_IDX+2]);
        assign lane_type[i]  = btb_type[bidx];
        assign lane_tgt[i]   = btb_target[bidx];
        assign lane_cond[i]  = hit && (btb_type[bidx] == BR_COND);
        assign lane_taken[i] = hit && ((btb_type[bidx] != BR_COND) || pht[pidx][1]);
    end

    // Lowest taken lane wins; upto_mask covers lanes up to it, or all lanes when none is taken.
    assign taken_onehot = lane_taken & (~lane_taken + FETCH_WIDTH'(1));
    assign upto_mask    = taken_onehot | (taken_onehot - FETCH_WIDTH'(1));
    assign sel_found    = |lane_taken;
    assign sel_is_cond  = |(taken_onehot & lane_cond);
    assign cond_upto    = |(upto_mask & lane_cond);

    // One-hot mux of the selected lane's BTB fields and PC.
    always_comb begin
        sel_tgt  = 32'h0000_0000;
        sel_type = 2'b00;
        sel_pc   = 32'h0000_0000;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            sel_tgt  = sel_tgt  | ({32{taken_onehot[i]}} & lane_tgt[i]);
            sel_type = sel_type | ({2{taken_onehot[i]}}  & lane_type[i]);
            sel_pc   = sel_pc   | ({32{taken_onehot[i]}} & lane_pc[i]);
        end
    end

    // Next fetch PC; a return with an empty stack falls back to the BTB target.
    always_comb begin
        if (!sel_found) begin
            next_pc_c = pc_in + 32'(4 * FETCH_WIDTH);
        end else if ((sel_type == BR_RET) && (ras_cnt != {(RAS_IDX+1){1'b0}})) begin
            next_pc_c = ras[ras_tos];
        end else begin
            next_pc_c = sel_tgt;
        end
    end

    assign taken_branch = taken_onehot;
    assign next_pc      = next_pc_c;
    assign ckpt_out     = {ghr, ras_tos, ras_cnt};

    logic push_s, pop_s;
    assign push_s = fetch_valid && !must_flush && sel_found && (sel_type == BR_CALL);
    assign pop_s  = fetch_valid && !must_flush && sel_found && (sel_type == BR_RET) &&
                    (ras_cnt != {(RAS_IDX+1){1'b0}});

    // Speculative history and stack pointers; flush restores the checkpoint.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr     <= {GHR_BITS{1'b0}};
            ras_tos <= {RAS_IDX{1'b0}};
            ras_cnt <= {(RAS_IDX+1){1'b0}};
        end else if (must_flush) begin
            {ghr, ras_tos, ras_cnt} <= flush_ckpt;
            if (new_entry && (br_type == BR_COND)) begin
                ghr <= ghr_shift(flush_ckpt[GHR_BITS+2*RAS_IDX:2*RAS_IDX+1], is_taken);
            end
        end else if (fetch_valid) begin
            if (push_s) begin
                ras_tos <= ras_tos + 1'b1;
                ras_cnt <= (ras_cnt == RAS_FULL) ? ras_cnt : ras_cnt + 1'b1;
            end else if (pop_s) begin
                ras_tos <= ras_tos - 1'b1;
                ras_cnt <= ras_cnt - 1'b1;
            end
            if (sel_is_cond) begin
                ghr <= ghr_shift(ghr, 1'b1);
            end else if (cond_upto) begin
                ghr <= ghr_shift(ghr, 1'b0);
            end
        end
    end

    // Return stack storage; a push on a full stack overwrites the oldest slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            ras[ras_tos + 1'b1] <= sel_pc + 32'd4;
        end
    end

    // Direction counters trained by resolved conditional branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (new_entry && (br_type == BR_COND)) begin
            pht[pht_index(pc_orig[PHT_IDX+1:2], upd_ghr)] <=
                pht_sat(pht[pht_index(pc_orig[PHT_IDX+1:2], upd_ghr)], is_taken);
        end
    end

    logic               btb_wr;
    logic [BTB_IDX-1:0] wr_idx;
    logic [BTB_IDX-1:0] inv_idx;
    assign btb_wr  = new_entry && (is_taken || (br_type != BR_COND));
    assign wr_idx  = pc_orig[BTB_IDX+1:2];
    assign inv_idx = old_pc[BTB_IDX+1:2];

    // Valid bits: invalidate on tag match, a same-cycle write to the slot wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= {BTB_SIZE{1'b0}};
        end else begin
            if (invalidate && (btb_tag[inv_idx] == old_pc[31:BTB_IDX+2])) begin
                btb_valid[inv_idx] <= 1'b0;
            end
            if (btb_wr) begin
                btb_valid[wr_idx] <= 1'b1;
            end
        end
    end

    // BTB payload, qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[wr_idx]    <= pc_orig[31:BTB_IDX+2];
            btb_target[wr_idx] <= target_pc;
            btb_type[wr_idx]   <= br_type;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pc_orig[1:0], old_pc[1:0]};

endmodule

// File: tb/tb_predictor_mw.sv
// Scoreboard bench for predictor_mw: expected lookup results are queued with each
// stimulus and compared against the combinational outputs mid-cycle.
module tb_predictor_mw;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        fetch_valid;
    logic [1:0]  taken_branch;
    logic [31:0] next_pc;
    logic [10:0] ckpt_out;
    logic        must_flush;
    logic [10:0] flush_ckpt;
    logic        new_entry;
    logic [31:0] pc_orig;
    logic [31:0] target_pc;
    logic        is_taken;
    logic [1:0]  br_type;
    logic [3:0]  upd_ghr;
    logic        invalidate;
    logic [31:0] old_pc;

    predictor_mw dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_valid(fetch_valid),
        .taken_branch(taken_branch), .next_pc(next_pc), .ckpt_out(ckpt_out),
        .must_flush(must_flush), .flush_ckpt(flush_ckpt), .new_entry(new_entry),
        .pc_orig(pc_orig), .target_pc(target_pc), .is_taken(is_taken), .br_type(br_type),
        .upd_ghr(upd_ghr), .invalidate(invalidate), .old_pc(old_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [1:0]  tb;
        logic [31:0] npc;
        logic [10:0] ck;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ck(input int g, input int t, input int c);
        return {4'(g), 3'(t), 4'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] tb,
                              input logic [31:0] npc, input logic [10:0] c);
        exp_t e;
        e.tag = tag; e.tb = tb; e.npc = npc; e.ck = c;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            check_val({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, "_taken"}, 32'(taken_branch), 32'(e.tb));
            check_val({e.tag, "_npc"}, next_pc, e.npc);
            check_val({e.tag, "_ckpt"}, 32'(ckpt_out), 32'(e.ck));
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic fv,
                          input logic [1:0] tb, input logic [31:0] npc, input logic [10:0] c);
        pc_in = pc;
        fetch_valid = fv;
        expect_out(tag, tb, npc, c);
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic btb_write(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ,
                             input logic tk, input logic [3:0] g);
        new_entry = 1'b1; pc_orig = pc; target_pc = tgt; br_type = typ; is_taken = tk; upd_ghr = g;
        tick();
        new_entry = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pc_in = 32'h100; fetch_valid = 1'b0; must_flush = 1'b0; flush_ckpt = 11'd0;
        new_entry = 1'b0; pc_orig = 32'd0; target_pc = 32'd0; is_taken = 1'b0; br_type = 2'b00;
        upd_ghr = 4'd0; invalidate = 1'b0; old_pc = 32'd0;
        #2;
        expect_out("reset", 2'b00, 32'h108, ck(0, 0, 0));
        tick();
        rst = 1'b0;

        lookup("empty", 32'h100, 1'b1, 2'b00, 32'h108, ck(0, 0, 0));

        btb_write(32'h104, 32'h200, 2'b00, 1'b1, 4'd0);
        btb_write(32'h104, 32'h200, 2'b00, 1'b1, 4'd0);
        lookup("cond_taken", 32'h100, 1'b1, 2'b10, 32'h200, ck(0, 0, 0));
        lookup("ghr_shift", 32'h100, 1'b0, 2'b00, 32'h108, ck(1, 0, 0));

        btb_write(32'h100, 32'h400, 2'b10, 1'b1, 4'd0);
        btb_write(32'h404, 32'hABC, 2'b11, 1'b1, 4'd0);
        lookup("call", 32'h100, 1'b1, 2'b01, 32'h400, ck(1, 0, 0));
        lookup("ret", 32'h404, 1'b1, 2'b01, 32'h104, ck(1, 1, 1));
        lookup("ret_empty", 32'h404, 1'b1, 2'b01, 32'hABC, ck(1, 0, 0));

        for (int k = 1; k <= 9; k++) begin
            logic [31:0] pk;
            pk = (32'(k) << 8) | 32'h20;
            btb_write(pk, 32'h400, 2'b10, 1'b1, 4'd0);
            lookup($sformatf("call%0d", k), pk, 1'b1, 2'b01, 32'h400,
                   ck(1, (k - 1) % 8, (k - 1 > 8) ? 8 : k - 1));
        end
        for (int j = 0; j < 8; j++) begin
            lookup($sformatf("ret_lifo%0d", j), 32'h404, 1'b1, 2'b01,
                   (32'(9 - j) << 8) | 32'h24, ck(1, (9 - j) % 8, 8 - j));
        end
        lookup("ret_drained", 32'h404, 1'b1, 2'b01, 32'hABC, ck(1, 1, 0));

        btb_write(32'h340, 32'h500, 2'b00, 1'b1, 4'd1);
        lookup("gs_a", 32'h340, 1'b1, 2'b01, 32'h500, ck(1, 1, 0));
        lookup("gs_b", 32'h340, 1'b1, 2'b00, 32'h348, ck(3, 1, 0));
        must_flush = 1'b1; flush_ckpt = ck(1, 1, 0);
        lookup("flush_cyc", 32'h340, 1'b1, 2'b00, 32'h348, ck(6, 1, 0));
        must_flush = 1'b0;
        lookup("restored", 32'h340, 1'b0, 2'b01, 32'h500, ck(1, 1, 0));

        must_flush = 1'b1; flush_ckpt = ck(1, 5, 3);
        btb_write(32'h340, 32'h0, 2'b00, 1'b0, 4'hF);
        must_flush = 1'b0;
        lookup("flush_shift", 32'h340, 1'b0, 2'b00, 32'h348, ck(2, 5, 3));

        btb_write(32'h104, 32'h600, 2'b01, 1'b1, 4'd0);
        lookup("both_taken", 32'h100, 1'b0, 2'b01, 32'h400, ck(2, 5, 3));
        invalidate = 1'b1; old_pc = 32'h204;
        tick();
        invalidate = 1'b0;
        lookup("inv_tag_miss", 32'h100, 1'b0, 2'b01, 32'h400, ck(2, 5, 3));
        invalidate = 1'b1; old_pc = 32'h100;
        tick();
        invalidate = 1'b0;
        lookup("inv_lane1", 32'h100, 1'b0, 2'b10, 32'h600, ck(2, 5, 3));
        invalidate = 1'b1; old_pc = 32'h104;
        btb_write(32'h104, 32'h700, 2'b01, 1'b1, 4'd0);
        invalidate = 1'b0;
        lookup("inv_vs_wr", 32'h100, 1'b0, 2'b10, 32'h700, ck(2, 5, 3));
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 2'b00, 32'h4, ck(2, 5, 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
